dec_ref_aligner: RTL and testbench

- Latency-matching buffer directly upstream of dec_comparator.
- Stores the original (pre-encoder) reference words in a FIFO until the decoder produces the matching decoded word. It then presents the aligned pair on A and B for one cycle.
- Consumes the comparator's isEqual result and keeps pair and mismatch statistics.
- Sits between the encoder input tap, the decoder output and dec_comparator.

---
 rtl/dec_pkg.sv | 21 ++
 rtl/dec_sync_fifo.sv | 78 +++++++
 rtl/dec_ref_aligner.sv | 155 +++++++++++++++
 tb/tb_dec_ref_aligner.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg
// Shared definitions for the decoder reference-alignment path.
//   DEC_DATA_DEPTH : default data word width (must match dec_comparator)
//   dec_word_t     : one data word of DEC_DATA_DEPTH bits
//   sat_inc()      : saturating increment used by the statistics counters
// -----------------------------------------------------------------------------
package dec_pkg;

    localparam int DEC_DATA_DEPTH = 8;

    typedef logic [DEC_DATA_DEPTH-1:0] dec_word_t;

    // Saturating +1 on a value of up to 32 bits. The caller passes its own
    // all-ones ceiling so the same function serves any counter width <= 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage : dec_pkg

// File: rtl/dec_sync_fifo.sv
// -----------------------------------------------------------------------------
// dec_sync_fifo
// Single-clock circular FIFO with a separate occupancy counter.
// The head word is presented combinationally on rd_data (first-word
// fall-through), so a pop consumes the word visible in the same cycle.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (pointers and level to 0)
//   flush    in   synchronous clear; overrides push and pop this cycle
//   push     in   write request; ignored while full
//   pop      in   read request; ignored while empty
//   wr_data  in   WIDTH  word to write
//   rd_data  out  WIDTH  head word (valid when !empty)
//   full     out  level == DEPTH
//   empty    out  level == 0
//   level    out  $clog2(DEPTH)+1  current occupancy
// -----------------------------------------------------------------------------
module dec_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; stale words are unreachable
    // because level/pointers are reset, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Pointers are exactly AW bits wide, so they wrap at DEPTH
            // for free (DEPTH is a power of two).
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule : dec_sync_fifo

// File: rtl/dec_ref_aligner.sv
// -----------------------------------------------------------------------------
// dec_ref_aligner
// Latency-matching buffer in front of dec_comparator. Reference words taken
// at the encoder input are queued until the decoder emits the matching
// decoded word; the pair is then registered onto A (decoded) and B (reference)
// with cmp_valid high for one cycle. The comparator's isEqual verdict is
// folded back into saturating pair / mismatch counters.
//
// Optional build macro: DEC_ALIGN_FIRST_ERR_EN
//   When defined, the first mismatching A/B pair since rst is captured on
//   first_err_valid / first_err_A / first_err_B.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   flush      in   clears the reference queue; counters and flags kept
//   ref_valid  in   reference word offered
//   ref_data   in   DATA_DEPTH reference word
//   ref_ready  out  queue can accept a reference word (not full)
//   dec_valid  in   decoded word present (no backpressure)
//   dec_data   in   DATA_DEPTH decoded word
//   A          out  DATA_DEPTH registered decoded word
//   B          out  DATA_DEPTH registered reference word
//   cmp_valid  out  A/B pair valid this cycle
//   isEqual    in   comparator verdict for the current A/B
//   level      out  queue occupancy
//   underflow  out  sticky: decoded word arrived with the queue empty
//   overflow   out  sticky: reference word offered while not ready
//   pair_cnt   out  CNT_W compared pairs (saturating)
//   err_cnt    out  CNT_W mismatching pairs (saturating)
// -----------------------------------------------------------------------------
module dec_ref_aligner
    import dec_pkg::*;
#(
    parameter int DATA_DEPTH = DEC_DATA_DEPTH,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          ref_valid,
    input  logic [DATA_DEPTH-1:0]         ref_data,
    output logic                          ref_ready,
    input  logic                          dec_valid,
    input  logic [DATA_DEPTH-1:0]         dec_data,
    output logic [DATA_DEPTH-1:0]         A,
    output logic [DATA_DEPTH-1:0]         B,
    output logic                          cmp_valid,
    input  logic                          isEqual,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          underflow,
    output logic                          overflow,
    output logic [CNT_W-1:0]              pair_cnt,
    output logic [CNT_W-1:0]              err_cnt
`ifdef DEC_ALIGN_FIRST_ERR_EN
    ,
    output logic                          first_err_valid,
    output logic [DATA_DEPTH-1:0]         first_err_A,
    output logic [DATA_DEPTH-1:0]         first_err_B
`endif
);

    // Counters are stepped through the 32-bit sat_inc helper.
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_DEPTH-1:0] head;
    logic                  push;
    logic                  pop;
    logic                  ovf_event;
    logic                  unf_event;

    // flush swallows any push/pop in its cycle and never raises a flag.
    assign ref_ready = !fifo_full;
    assign push      = ref_valid && ref_ready && !flush;
    assign pop       = dec_valid && !fifo_empty && !flush;
    assign ovf_event = ref_valid && !ref_ready && !flush;
    // No bypass: a decoded word seen while empty is dropped even if a
    // reference word is being pushed in the same cycle.
    assign unf_event = dec_valid && fifo_empty && !flush;

    dec_sync_fifo #(
        .WIDTH (DATA_DEPTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (ref_data),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Alignment register: one cycle from dec_valid to the A/B pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            A         <= '0;
            B         <= '0;
            cmp_valid <= 1'b0;
        end else if (pop) begin
            A         <= dec_data;
            B         <= head;
            cmp_valid <= 1'b1;
        end else begin
            cmp_valid <= 1'b0;
        end
    end

    // Sticky error flags, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (unf_event) underflow <= 1'b1;
            if (ovf_event) overflow  <= 1'b1;
        end
    end

    // Statistics follow the comparator verdict for the pair currently on A/B;
    // flush does not touch them.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_cnt <= '0;
            err_cnt  <= '0;
        end else if (cmp_valid) begin
            pair_cnt <= CNT_W'(sat_inc(32'(pair_cnt), CNT_MAX));
            if (!isEqual) begin
                err_cnt <= CNT_W'(sat_inc(32'(err_cnt), CNT_MAX));
            end
        end
    end

`ifdef DEC_ALIGN_FIRST_ERR_EN
    // Captures only the first mismatch since rst, then freezes.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_err_valid <= 1'b0;
            first_err_A     <= '0;
            first_err_B     <= '0;
        end else if (cmp_valid && !isEqual && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_A     <= A;
            first_err_B     <= B;
        end
    end
`endif

endmodule : dec_ref_aligner

// File: tb/tb_dec_ref_aligner.sv
// -----------------------------------------------------------------------------
// tb_dec_ref_aligner
// Directed bench for dec_ref_aligner (FIFO_DEPTH=16, CNT_W=4 so counter
// saturation is reachable). The comparator is modelled as isEqual = (A == B).
// Each expected A/B pair, with the cycle it must appear in, is queued when
// the matching dec_valid is driven; a monitor pops it on every cmp_valid.
// -----------------------------------------------------------------------------
module tb_dec_ref_aligner;
    import dec_pkg::*;

    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    typedef struct {
        dec_word_t a;
        dec_word_t b;
        int        cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             ref_valid;
    dec_word_t        ref_data;
    logic             ref_ready;
    logic             dec_valid;
    dec_word_t        dec_data;
    dec_word_t        A;
    dec_word_t        B;
    logic             cmp_valid;
    logic             isEqual;
    logic [LVL_W-1:0] level;
    logic             underflow;
    logic             overflow;
    logic [CNT_W-1:0] pair_cnt;
    logic [CNT_W-1:0] err_cnt;
`ifdef DEC_ALIGN_FIRST_ERR_EN
    logic             first_err_valid;
    dec_word_t        first_err_A;
    dec_word_t        first_err_B;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Comparator stand-in.
    assign isEqual = (A == B);

    dec_ref_aligner #(
        .DATA_DEPTH (DEC_DATA_DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .ref_valid       (ref_valid),
        .ref_data        (ref_data),
        .ref_ready       (ref_ready),
        .dec_valid       (dec_valid),
        .dec_data        (dec_data),
        .A               (A),
        .B               (B),
        .cmp_valid       (cmp_valid),
        .isEqual         (isEqual),
        .level           (level),
        .underflow       (underflow),
        .overflow        (overflow),
        .pair_cnt        (pair_cnt),
        .err_cnt         (err_cnt)
`ifdef DEC_ALIGN_FIRST_ERR_EN
        ,
        .first_err_valid (first_err_valid),
        .first_err_A     (first_err_A),
        .first_err_B     (first_err_B)
`endif
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every cmp_valid pulse must match the oldest expected pair.
    always @(negedge clk) begin
        if (cmp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cmp_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pair_A",       32'(A),   32'(e.a));
                check("pair_B",       32'(B),   32'(e.b));
                check("pair_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // One clock of stimulus. Called just after a rising edge; the inputs are
    // sampled at the next edge, and the pair (if any) must appear right after it.
    task automatic step(input logic rv, input dec_word_t rd,
                        input logic dv, input dec_word_t dd,
                        input logic fl, input logic exp_pop,
                        input dec_word_t exp_b);
        ref_valid = rv;
        ref_data  = rd;
        dec_valid = dv;
        dec_data  = dd;
        flush     = fl;
        if (exp_pop) begin
            exp_t e;
            e.a   = dd;
            e.b   = exp_b;
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        ref_valid = 1'b0;
        dec_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic push_ref(input dec_word_t d);
        step(1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic dec_word(input dec_word_t d, input dec_word_t exp_b);
        step(1'b0, 8'h00, 1'b1, d, 1'b0, 1'b1, exp_b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        ref_valid = 1'b0;
        ref_data  = '0;
        dec_valid = 1'b0;
        dec_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_level",     32'(level),     32'd0);
        check("rst_ref_ready", 32'(ref_ready), 32'd1);
        check("rst_cmp_valid", 32'(cmp_valid), 32'd0);
        check("rst_flags",     32'({underflow, overflow}), 32'd0);
        check("rst_counts",    32'({pair_cnt, err_cnt}),   32'd0);

        // 1: three matching pairs back to back.
        push_ref(8'h11);
        push_ref(8'h22);
        push_ref(8'h33);
        check("t1_level3", 32'(level), 32'd3);
        dec_word(8'h11, 8'h11);
        dec_word(8'h22, 8'h22);
        dec_word(8'h33, 8'h33);
        idle(2);
        check("t1_pair_cnt", 32'(pair_cnt), 32'd3);
        check("t1_err_cnt",  32'(err_cnt),  32'd0);
        check("t1_level0",   32'(level),    32'd0);

        // 2: a mismatching pair.
        push_ref(8'h5A);
        dec_word(8'h5B, 8'h5A);
        idle(2);
        check("t2_pair_cnt", 32'(pair_cnt), 32'd4);
        check("t2_err_cnt",  32'(err_cnt),  32'd1);
`ifdef DEC_ALIGN_FIRST_ERR_EN
        check("t2_first_err_valid", 32'(first_err_valid), 32'd1);
        check("t2_first_err_A",     32'(first_err_A),     32'h5B);
        check("t2_first_err_B",     32'(first_err_B),     32'h5A);
`endif

        // 3: fill, overflow, then pop with a blocked push.
        for (int i = 0; i < FIFO_DEPTH; i++) push_ref(dec_word_t'(8'h80 + i));
        check("t3_level_full", 32'(level),     32'd16);
        check("t3_not_ready",  32'(ref_ready), 32'd0);
        check("t3_no_ovf_yet", 32'(overflow),  32'd0);
        push_ref(8'hEE);
        check("t3_overflow",   32'(overflow),  32'd1);
        check("t3_level_held", 32'(level),     32'd16);
        step(1'b1, 8'hEF, 1'b1, 8'h80, 1'b0, 1'b1, 8'h80);
        check("t3_level15",    32'(level),     32'd15);
        check("t3_ready_back", 32'(ref_ready), 32'd1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        check("t3_flushed",    32'(level),     32'd0);
        idle(1);
        check("t3_pair_cnt",   32'(pair_cnt),  32'd5);

        // 4: dec while empty with a same-cycle push: no bypass.
        check("t4_no_unf_yet", 32'(underflow), 32'd0);
        step(1'b1, 8'h77, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
        check("t4_no_cmp",     32'(cmp_valid), 32'd0);
        check("t4_underflow",  32'(underflow), 32'd1);
        check("t4_level1",     32'(level),     32'd1);
        dec_word(8'h77, 8'h77);
        idle(2);
        check("t4_pair_cnt",   32'(pair_cnt),  32'd6);

        // 5: flush together with dec_valid.
        for (int i = 1; i <= 5; i++) push_ref(dec_word_t'(i));
        check("t5_level5",   32'(level), 32'd5);
        step(1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00);
        check("t5_level0",   32'(level),     32'd0);
        check("t5_no_cmp",   32'(cmp_valid), 32'd0);
        check("t5_flags",    32'({underflow, overflow}), 32'd3);
        idle(1);
        check("t5_pair_cnt", 32'(pair_cnt), 32'd6);
        check("t5_err_cnt",  32'(err_cnt),  32'd1);

        // 6: drive 20 more pairs; pair_cnt saturates at 0xF.
        for (int i = 0; i < 20; i++) begin
            push_ref(dec_word_t'(8'hC0 + i));
            dec_word(dec_word_t'(8'hC0 + i), dec_word_t'(8'hC0 + i));
        end
        idle(2);
        check("t6_pair_sat", 32'(pair_cnt), 32'hF);
        check("t6_err_cnt",  32'(err_cnt),  32'd1);

        // Reset mid-operation, with a pop requested in the reset cycle.
        push_ref(8'h99);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        check("t6_rst_level",     32'(level),     32'd0);
        check("t6_rst_ready",     32'(ref_ready), 32'd1);
        check("t6_rst_cmp_valid", 32'(cmp_valid), 32'd0);
        check("t6_rst_AB",        32'({A, B}),    32'd0);
        check("t6_rst_flags",     32'({underflow, overflow}), 32'd0);
        check("t6_rst_counts",    32'({pair_cnt, err_cnt}),   32'd0);
`ifdef DEC_ALIGN_FIRST_ERR_EN
        check("t6_rst_first_err", 32'({first_err_valid, first_err_A, first_err_B}), 32'd0);
`endif
        idle(2);
        check("t6_post_rst_no_cmp", 32'(cmp_valid), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_dec_ref_aligner
